// File: rtl/alu_result_capture_pkg.sv
// Shared definitions for the ALU result return path.
//   ALU_WIDTH  : default result width, matching the 4-bit operand path.
//   FLAGS_W    : width of the ALU flags field.
//   FLAG_CARRY : bit index of the carry flag inside the flags field.
//   FLAG_ZERO  : bit index of the zero flag inside the flags field.
package alu_result_capture_pkg;

  localparam int ALU_WIDTH  = 4;
  localparam int FLAGS_W    = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_ZERO  = 0;

endpackage : alu_result_capture_pkg

// File: rtl/alu_result_mem.sv
// Register-array storage for captured ALU results.
// One synchronous write port, one asynchronous (combinational) read port.
// Contents are not reset; only the pointers in the parent qualify them.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data ({flags, result})
//   raddr : read address
//   rdata : read data, combinational from raddr
module alu_result_mem #(
  parameter int ENTRY_W = 6,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : alu_result_mem

// File: rtl/alu_result_capture.sv
// Collects ALU results and flags into a small FIFO and presents the oldest
// entry to the downstream consumer under an enable/accept handshake. Data
// outputs are forced to zero whenever no entry is presented.
//   clk          : clock
//   rst          : asynchronous active-high reset
//   in_valid     : ALU result valid this cycle
//   in_result    : ALU result data
//   in_flags     : ALU flags, [1]=carry, [0]=zero
//   in_ready     : block can accept a push (not full)
//   out_en       : consumer accepts the presented entry
//   out_valid    : head entry is presented (not empty)
//   out_result   : head result, zero when out_valid=0
//   out_flags    : head flags, zero when out_valid=0
//   count        : number of stored entries
//   err_clr      : synchronous clear of overflow_err
//   overflow_err : sticky, set when in_valid arrives while full
module alu_result_capture
  import alu_result_capture_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_result,
  input  logic [FLAGS_W-1:0]         in_flags,
  output logic                       in_ready,
  input  logic                       out_en,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_result,
  output logic [FLAGS_W-1:0]         out_flags,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       err_clr,
  output logic                       overflow_err
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = WIDTH + FLAGS_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENTRY_W-1:0] head;
  logic               push;
  logic               pop;
  logic               drop;

  // Full/empty come from count alone, so ready never depends on out_en:
  // a pop in the same cycle as a full-state push does not rescue the push.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_en;
  assign drop = in_valid && !in_ready;

  alu_result_mem #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_flags, in_result}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointer and occupancy state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // push is already blocked when full and pop when empty, so the
      // count stays within 0..DEPTH without extra clamping.
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a new drop in the clearing cycle keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_err <= 1'b0;
    end else if (drop) begin
      overflow_err <= 1'b1;
    end else if (err_clr) begin
      overflow_err <= 1'b0;
    end
  end

  // Output gating: zeros whenever nothing is presented
  assign out_result = head[WIDTH-1:0] & {WIDTH{out_valid}};
  assign out_flags  = head[ENTRY_W-1:WIDTH] & {FLAGS_W{out_valid}};

endmodule : alu_result_capture

// File: tb/tb_alu_result_capture.sv
module tb_alu_result_capture;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_result;
  logic [1:0]       in_flags;
  logic             in_ready;
  logic             out_en;
  logic             out_valid;
  logic [WIDTH-1:0] out_result;
  logic [1:0]       out_flags;
  logic [2:0]       count;
  logic             err_clr;
  logic             overflow_err;

  int ncomp = 0;
  int nfail = 0;

  // Scoreboard: {flags, result} of every entry the FIFO should hold.
  logic [5:0] sb[$];
  logic       exp_ovf;

  alu_result_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .in_ready     (in_ready),
    .out_en       (out_en),
    .out_valid    (out_valid),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .count        (count),
    .err_clr      (err_clr),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor on the falling edge: compare outputs to the scoreboard, then
  // advance the scoreboard by what the coming rising edge should do.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_ovf = 1'b0;
    end else begin
      ncomp++;
      if (count !== 3'(sb.size())) begin
        nfail++;
        $display("FAIL mon_count: got %0d want %0d", count, sb.size());
      end
      ncomp++;
      if (in_ready !== (sb.size() != DEPTH)) begin
        nfail++;
        $display("FAIL mon_in_ready: got %b want %b", in_ready, sb.size() != DEPTH);
      end
      ncomp++;
      if (out_valid !== (sb.size() != 0)) begin
        nfail++;
        $display("FAIL mon_out_valid: got %b want %b", out_valid, sb.size() != 0);
      end
      ncomp++;
      if (sb.size() != 0) begin
        if ({out_flags, out_result} !== sb[0]) begin
          nfail++;
          $display("FAIL mon_head: got %b_%b want %b_%b", out_flags, out_result, sb[0][5:4], sb[0][3:0]);
        end
      end else if ({out_flags, out_result} !== 6'b0) begin
        nfail++;
        $display("FAIL mon_idle_zero: got %b_%b want 00_0000", out_flags, out_result);
      end
      ncomp++;
      if (overflow_err !== exp_ovf) begin
        nfail++;
        $display("FAIL mon_overflow_err: got %b want %b", overflow_err, exp_ovf);
      end
      begin
        bit full, do_pop, acc;
        full   = (sb.size() == DEPTH);
        do_pop = (sb.size() != 0) && out_en;
        acc    = in_valid && !full;
        if (in_valid && full) exp_ovf = 1'b1;
        else if (err_clr)     exp_ovf = 1'b0;
        if (do_pop) void'(sb.pop_front());
        if (acc) sb.push_back({in_flags, in_result});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_result = '0;
    in_flags  = '0;
    out_en    = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    out_en = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    out_en = 1'b0;
  endtask

  task automatic fill(input logic [3:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      in_valid  = 1'b1;
      in_result = base + 4'(i);
      in_flags  = 2'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    // store two entries, then reset asynchronously between edges
    in_valid = 1'b1; in_result = 4'h6; in_flags = 2'b01; tick();
    in_result = 4'h7; in_flags = 2'b11; tick();
    in_valid = 1'b0;
    ncomp++;
    if (count !== 3'd2) begin
      nfail++; $display("FAIL rst_precount: got %0d want 2", count);
    end
    #1 rst = 1'b1;
    #1;
    ncomp++;
    if ({out_valid, out_flags, out_result, count, in_ready, overflow_err} !== {1'b0, 2'b00, 4'h0, 3'd0, 1'b1, 1'b0}) begin
      nfail++;
      $display("FAIL async_reset: got v=%b f=%b r=%b c=%0d rdy=%b err=%b want v=0 f=00 r=0000 c=0 rdy=1 err=0",
               out_valid, out_flags, out_result, count, in_ready, overflow_err);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_result = 4'b1010; in_flags = 2'b10;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ncomp++;
      if ({out_valid, out_flags, out_result, count} !== {1'b1, 2'b10, 4'b1010, 3'd1}) begin
        nfail++;
        $display("FAIL single_hold%0d: got v=%b f=%b r=%b c=%0d want v=1 f=10 r=1010 c=1",
                 i, out_valid, out_flags, out_result, count);
      end
      tick();
    end
    out_en = 1'b1;
    tick();
    out_en = 1'b0;
    ncomp++;
    if ({out_valid, out_flags, out_result} !== 7'b0) begin
      nfail++;
      $display("FAIL single_pop: got v=%b f=%b r=%b want all zero", out_valid, out_flags, out_result);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_result = 4'(i); in_flags = 2'b00;
      tick();
    end
    in_valid = 1'b0;
    ncomp++;
    if ({count, in_ready, overflow_err} !== {3'd4, 1'b0, 1'b1}) begin
      nfail++;
      $display("FAIL fill_ovf: got c=%0d rdy=%b err=%b want c=4 rdy=0 err=1", count, in_ready, overflow_err);
    end
    out_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      ncomp++;
      if (out_result !== 4'(i)) begin
        nfail++;
        $display("FAIL fill_order%0d: got %0d want %0d", i, out_result, i);
      end
      tick();
    end
    out_en = 1'b0;
    ncomp++;
    if (out_valid !== 1'b0) begin
      nfail++; $display("FAIL fill_empty: got v=%b want 0 (entry 5 should be dropped)", out_valid);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    ncomp++;
    if (overflow_err !== 1'b0) begin
      nfail++; $display("FAIL err_clr: got %b want 0", overflow_err);
    end
  endtask

  task automatic test_streaming();
    out_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_result = 4'(i); in_flags = 2'(i);
      tick();
      ncomp++;
      if (count !== 3'd1) begin
        nfail++; $display("FAIL stream_count%0d: got %0d want 1", i, count);
      end
    end
    in_valid = 1'b0;
    tick();
    out_en = 1'b0;
    ncomp++;
    if ({count, overflow_err} !== {3'd0, 1'b0}) begin
      nfail++; $display("FAIL stream_end: got c=%0d err=%b want c=0 err=0", count, overflow_err);
    end
  endtask

  task automatic test_full_pop();
    fill(4'h8);
    in_valid = 1'b1; in_result = 4'hF; in_flags = 2'b11; out_en = 1'b1;
    tick();
    in_valid = 1'b0; out_en = 1'b0;
    ncomp++;
    if ({count, overflow_err, out_result} !== {3'd3, 1'b1, 4'h9}) begin
      nfail++;
      $display("FAIL full_pop: got c=%0d err=%b head=%0h want c=3 err=1 head=9", count, overflow_err, out_result);
    end
    drain();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  task automatic test_collision();
    fill(4'h3);
    in_valid = 1'b1; in_result = 4'hE; err_clr = 1'b1;
    tick();
    in_valid = 1'b0; err_clr = 1'b0;
    ncomp++;
    if ({overflow_err, count} !== {1'b1, 3'd4}) begin
      nfail++; $display("FAIL collision: got err=%b c=%0d want err=1 c=4", overflow_err, count);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    ncomp++;
    if (overflow_err !== 1'b0) begin
      nfail++; $display("FAIL collision_clr: got %b want 0", overflow_err);
    end
    drain();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    ncomp++;
    if ({out_valid, count, in_ready, overflow_err} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
      nfail++;
      $display("FAIL reset_state: got v=%b c=%0d rdy=%b err=%b want v=0 c=0 rdy=1 err=0",
               out_valid, count, in_ready, overflow_err);
    end
    test_reset();
    test_single();
    test_fill_overflow();
    test_streaming();
    test_full_pop();
    test_collision();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule : tb_alu_result_capture
